// File: rtl/gpu_vec_core.sv
// gpu_vec_core: vector register file with a lane-serial ALU
// behind a single-master stb/ack command port.
`timescale 1ns/1ps
module gpu_vec_core #(
  parameter int LANES  = 4,
  parameter int LANE_W = 16,
  parameter int NREGS  = 16,
  localparam int DATA_W = LANES * LANE_W,
  localparam int RAW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       command,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              stb,
  output logic              ack,
  output logic              err
);

  localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [3:0] OP_READ = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] op_a, op_b, res_q;
  logic [3:0]        op_q;
  logic [RAW-1:0]    dst_q;
  logic              sat_q;
  logic [LCW-1:0]    lane_q;

  logic [3:0]        cmd_op;
  logic              cmd_alu;
  logic              lane_last;
  logic              unused_cmd;

  logic [LANE_W-1:0]   la, lb, lr;
  logic [LANE_W:0]     sum, dif;
  logic [2*LANE_W-1:0] prd;

  assign cmd_op     = command[15:12];
  assign cmd_alu    = (cmd_op >= OP_ADD) && (cmd_op <= OP_XOR);
  assign lane_last  = (lane_q == LCW'(LANES - 1));
  assign unused_cmd = ^command;

  assign ack = (state_q == DONE);
  assign err = ack && op_q[3];

  // One lane of the ALU; the lane counter selects the slice.
  always_comb begin
    la  = op_a[lane_q*LANE_W +: LANE_W];
    lb  = op_b[lane_q*LANE_W +: LANE_W];
    sum = {1'b0, la} + {1'b0, lb};
    dif = {1'b0, la} - {1'b0, lb};
    prd = {{LANE_W{1'b0}}, la} * {{LANE_W{1'b0}}, lb};
    lr  = '0;
    unique case (1'b1)
      (op_q == OP_ADD):
        lr = (sat_q && sum[LANE_W]) ? '1 : sum[LANE_W-1:0];
      (op_q == OP_SUB):
        lr = (sat_q && dif[LANE_W]) ? '0 : dif[LANE_W-1:0];
      (op_q == OP_MUL):
        lr = (sat_q && |prd[2*LANE_W-1:LANE_W]) ? '1
                                               : prd[LANE_W-1:0];
      (op_q == OP_AND): lr = la & lb;
      (op_q == OP_OR):  lr = la | lb;
      (op_q == OP_XOR): lr = la ^ lb;
      default:          lr = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (stb) state_d = cmd_alu ? EXEC : DONE;
      EXEC: if (lane_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // LOAD payload rides in res_q so the commit path is shared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      dst_q    <= '0;
      sat_q    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      res_q    <= '0;
      lane_q   <= '0;
      data_out <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (stb) begin
          op_q   <= cmd_op;
          dst_q  <= command[8 +: RAW];
          sat_q  <= command[16];
          op_a   <= regs[command[4 +: RAW]];
          op_b   <= regs[command[0 +: RAW]];
          lane_q <= '0;
          res_q  <= data_in;
        end
        EXEC: begin
          res_q[lane_q*LANE_W +: LANE_W] <= lr;
          lane_q <= lane_q + LCW'(1);
        end
        DONE: begin
          if (op_q == OP_READ)
            data_out <= op_a;
          else if (!op_q[3])
            regs[dst_q] <= res_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_vec_core.sv
// tb_gpu_vec_core: directed checks of gpu_vec_core with
// hand-computed vectors at default parameters.
`timescale 1ns/1ps
module tb_gpu_vec_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] command;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        stb;
  logic        ack;
  logic        err;

  int vecs;
  int errs;
  logic [14:0] rsv;

  localparam logic [3:0] RD  = 4'd0;
  localparam logic [3:0] LD  = 4'd1;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] SUB = 4'd3;
  localparam logic [3:0] MUL = 4'd4;
  localparam logic [3:0] AND = 4'd5;
  localparam logic [3:0] OR  = 4'd6;
  localparam logic [3:0] XOR = 4'd7;

  gpu_vec_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .command  (command),
    .data_in  (data_in),
    .data_out (data_out),
    .stb      (stb),
    .ack      (ack),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #12.5 clk = ~clk;
  end

  // Drives one command from a negedge; lat counts negedges to ack.
  task automatic issue(
    input  logic [3:0]  op,
    input  logic [3:0]  d,
    input  logic [3:0]  a,
    input  logic [3:0]  b,
    input  logic        s,
    input  logic [63:0] din,
    input  bit          drop,
    output int          lat,
    output logic        e,
    output logic        ack_after
  );
    command = {rsv, s, op, d, a, b};
    data_in = din;
    stb = 1'b1;
    lat = 99;
    e = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      data_in = ~din;
      if (drop) stb = 1'b0;
      if (ack) begin
        lat = k;
        e = err;
        break;
      end
    end
    stb = 1'b0;
    @(negedge clk);
    ack_after = ack;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stb = 1'b0;
    command = '0;
    data_in = '0;
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if ({ack, err, data_out} !== 66'd0) begin
        errs++;
        $display("FAIL reset_hold: ack=%b err=%b dout=%h want 0 0 0",
                 ack, err, data_out);
      end
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      vecs++;
      if ({ack, err, data_out} !== 66'd0) begin
        errs++;
        $display("FAIL idle: ack=%b err=%b dout=%h want 0 0 0",
                 ack, err, data_out);
      end
    end
  endtask

  task automatic test_read_empty();
    int lat;
    logic e, aa;
    issue(RD, 4'd0, 4'd5, 4'd0, 1'b0, '0, 0, lat, e, aa);
    vecs++;
    if (lat !== 1 || data_out !== 64'd0) begin
      errs++;
      $display("FAIL read_r5: lat=%0d dout=%h want 1 0", lat, data_out);
    end
  endtask

  task automatic test_load_read();
    int lat;
    logic e, aa;
    issue(LD, 4'd0, 4'd0, 4'd0, 1'b0, 64'h3000_2000_1000_0000, 0,
          lat, e, aa);
    vecs++;
    if (lat !== 1 || e !== 1'b0 || aa !== 1'b0) begin
      errs++;
      $display("FAIL load_ack: lat=%0d err=%b after=%b want 1 0 0",
               lat, e, aa);
    end
    vecs++;
    if (data_out !== 64'd0) begin
      errs++;
      $display("FAIL load_hold: dout=%h want 0", data_out);
    end
    issue(RD, 4'd0, 4'd0, 4'd0, 1'b0, '0, 0, lat, e, aa);
    vecs++;
    if (lat !== 1 || aa !== 1'b0 ||
        data_out !== 64'h3000_2000_1000_0000) begin
      errs++;
      $display("FAIL read_r0: lat=%0d after=%b dout=%h want 1 0 %h",
               lat, aa, data_out, 64'h3000_2000_1000_0000);
    end
  endtask

  task automatic test_add_sub();
    int lat;
    logic e, aa;
    logic [3:0] ops [3] = '{ADD, SUB, SUB};
    logic       sats [3] = '{1'b0, 1'b0, 1'b1};
    logic [63:0] exp [3] = '{64'hA000_8000_6000_4000,
                             64'hC000_C000_C000_C000,
                             64'h0};
    issue(LD, 4'd1, 4'd0, 4'd0, 1'b0, 64'h7000_6000_5000_4000, 0,
          lat, e, aa);
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 4'd2 + 4'(i), 4'd0, 4'd1, sats[i], '0, i == 2,
            lat, e, aa);
      vecs++;
      if (lat !== 5 || e !== 1'b0 || aa !== 1'b0) begin
        errs++;
        $display("FAIL addsub_ack%0d: lat=%0d err=%b after=%b want 5 0 0",
                 i, lat, e, aa);
      end
      issue(RD, 4'd0, 4'd2 + 4'(i), 4'd0, 1'b0, '0, 0, lat, e, aa);
      vecs++;
      if (data_out !== exp[i]) begin
        errs++;
        $display("FAIL addsub_val%0d: dout=%h want %h",
                 i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_mul_sat();
    int lat;
    logic e, aa;
    logic [3:0] ops [5] = '{MUL, ADD, ADD, MUL, MUL};
    logic [3:0] sa [5]  = '{4'd4, 4'd6, 4'd6, 4'd6, 4'd6};
    logic [3:0] sb [5]  = '{4'd5, 4'd6, 4'd6, 4'd6, 4'd6};
    logic       sats [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] exp [5] = '{64'h0700_0C00_0F00_1000,
                             64'hFFFF_FFFF_0002_0000,
                             64'hFFFE_0000_0002_0000,
                             64'hFFFF_FFFF_0001_0000,
                             64'h0001_0000_0001_0000};
    issue(LD, 4'd4, 4'd0, 4'd0, 1'b0, 64'h0070_0060_0050_0040, 0,
          lat, e, aa);
    issue(LD, 4'd5, 4'd0, 4'd0, 1'b0, 64'h0010_0020_0030_0040, 0,
          lat, e, aa);
    issue(LD, 4'd6, 4'd0, 4'd0, 1'b0, 64'hFFFF_8000_0001_0000, 0,
          lat, e, aa);
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], 4'd7 + 4'(i), sa[i], sb[i], sats[i], '0, 0,
            lat, e, aa);
      issue(RD, 4'd0, 4'd7 + 4'(i), 4'd0, 1'b0, '0, 0, lat, e, aa);
      vecs++;
      if (data_out !== exp[i]) begin
        errs++;
        $display("FAIL mulsat%0d: dout=%h want %h", i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_logic();
    int lat;
    logic e, aa;
    logic [3:0] ops [3] = '{AND, OR, XOR};
    logic [63:0] exp [3] = '{64'h3000_2000_1000_0000,
                             64'h7000_6000_5000_4000,
                             64'h4000_4000_4000_4000};
    rsv = 15'h5A5A;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 4'd12 + 4'(i), 4'd0, 4'd1, 1'b1, '0, 0,
            lat, e, aa);
      issue(RD, 4'd0, 4'd12 + 4'(i), 4'd0, 1'b0, '0, 0, lat, e, aa);
      vecs++;
      if (data_out !== exp[i]) begin
        errs++;
        $display("FAIL logic%0d: dout=%h want %h", i, data_out, exp[i]);
      end
    end
    rsv = '0;
  endtask

  task automatic test_alias_illegal();
    int lat;
    logic e, aa;
    issue(ADD, 4'd0, 4'd0, 4'd0, 1'b0, '0, 0, lat, e, aa);
    issue(RD, 4'd0, 4'd0, 4'd0, 1'b0, '0, 0, lat, e, aa);
    vecs++;
    if (data_out !== 64'h6000_4000_2000_0000) begin
      errs++;
      $display("FAIL alias: dout=%h want %h",
               data_out, 64'h6000_4000_2000_0000);
    end
    issue(RD, 4'd0, 4'd2, 4'd0, 1'b0, '0, 0, lat, e, aa);
    issue(4'd9, 4'd2, 4'd6, 4'd6, 1'b0, 64'h1111, 0, lat, e, aa);
    vecs++;
    if (lat !== 1 || e !== 1'b1 || aa !== 1'b0) begin
      errs++;
      $display("FAIL illegal_ack: lat=%0d err=%b after=%b want 1 1 0",
               lat, e, aa);
    end
    vecs++;
    if (data_out !== 64'hA000_8000_6000_4000) begin
      errs++;
      $display("FAIL illegal_hold: dout=%h want %h",
               data_out, 64'hA000_8000_6000_4000);
    end
    issue(RD, 4'd0, 4'd2, 4'd0, 1'b0, '0, 0, lat, e, aa);
    vecs++;
    if (e !== 1'b0 || data_out !== 64'hA000_8000_6000_4000) begin
      errs++;
      $display("FAIL post_illegal: err=%b dout=%h want 0 %h",
               e, data_out, 64'hA000_8000_6000_4000);
    end
  endtask

  task automatic test_back_to_back();
    command = {15'd0, 1'b0, RD, 4'd0, 4'd1, 4'd0};
    stb = 1'b1;
    @(negedge clk);
    vecs++;
    if (ack !== 1'b1) begin
      errs++;
      $display("FAIL b2b_ack1: ack=%b want 1", ack);
    end
    command = {15'd0, 1'b0, RD, 4'd0, 4'd0, 4'd0};
    @(negedge clk);
    vecs++;
    if (ack !== 1'b0 || data_out !== 64'h7000_6000_5000_4000) begin
      errs++;
      $display("FAIL b2b_gap: ack=%b dout=%h want 0 %h",
               ack, data_out, 64'h7000_6000_5000_4000);
    end
    @(negedge clk);
    vecs++;
    if (ack !== 1'b1) begin
      errs++;
      $display("FAIL b2b_ack2: ack=%b want 1", ack);
    end
    stb = 1'b0;
    @(negedge clk);
    vecs++;
    if (ack !== 1'b0 || data_out !== 64'h6000_4000_2000_0000) begin
      errs++;
      $display("FAIL b2b_val2: ack=%b dout=%h want 0 %h",
               ack, data_out, 64'h6000_4000_2000_0000);
    end
  endtask

  task automatic test_reset_mid_exec();
    int lat;
    logic e, aa;
    int acks;
    issue(LD, 4'd7, 4'd0, 4'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 0,
          lat, e, aa);
    command = {15'd0, 1'b0, ADD, 4'd7, 4'd1, 4'd1};
    stb = 1'b1;
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      acks += int'(ack);
    end
    rst_n = 1'b0;
    stb = 1'b0;
    repeat (2) begin
      @(negedge clk);
      acks += int'(ack);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      acks += int'(ack);
    end
    vecs++;
    if (acks !== 0 || dut.state_q !== dut.IDLE) begin
      errs++;
      $display("FAIL abort: acks=%0d state=%0d want 0 IDLE",
               acks, dut.state_q);
    end
    for (int r = 0; r < 16; r++) begin
      issue(RD, 4'd0, 4'(r), 4'd0, 1'b0, '0, 0, lat, e, aa);
      vecs++;
      if (lat !== 1 || data_out !== 64'd0) begin
        errs++;
        $display("FAIL post_rst_r%0d: lat=%0d dout=%h want 1 0",
                 r, lat, data_out);
      end
    end
    issue(LD, 4'd3, 4'd0, 4'd0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 0,
          lat, e, aa);
    issue(RD, 4'd0, 4'd3, 4'd0, 1'b0, '0, 0, lat, e, aa);
    vecs++;
    if (lat !== 1 || data_out !== 64'hDEAD_BEEF_CAFE_F00D) begin
      errs++;
      $display("FAIL post_rst_load: lat=%0d dout=%h want 1 %h",
               lat, data_out, 64'hDEAD_BEEF_CAFE_F00D);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rsv = '0;
    test_reset();
    test_read_empty();
    test_load_read();
    test_add_sub();
    test_mul_sat();
    test_logic();
    test_alias_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/gpu_vec_core.md
Name: gpu_vec_core

Overview:
- Parametrised successor to the fixed 4×16-bit GPU core.
- Register file of NREGS vector registers, each LANES lanes of LANE_W bits.
- Commands arrive over a single-master stb/ack command port and are executed by a lane-serial ALU, one lane per cycle.
- Adds over the previous generation: generic width/depth/lane count, SUB/MUL/logic ops, optional unsigned saturation, and an illegal-opcode error flag.

Parameters:
- LANES, 4: lanes per vector register (≥1).
- LANE_W, 16: bits per lane (≥2).
- NREGS, 16: number of vector registers (power of 2, 2..16).
- Derived localparam DATA_W = LANES*LANE_W.
- Derived localparam RAW = clog2(NREGS).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- command  input  32  [15:12] opcode, [11:8] dst, [7:4] srcA, [3:0] srcB (only low RAW bits of each register field used), [16] sat, [31:17] reserved/ignored.
- data_in  input  DATA_W  LOAD payload; lane i = bits [i*LANE_W +: LANE_W].
- data_out  output  DATA_W  READ result register.
- stb  input  1  command valid, held by master until ack.
- ack  output  1  one-cycle completion pulse.
- err  output  1  high with ack for illegal opcode, else 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ack=0, err=0, data_out=0; all registers and the result buffer = 0.
- FSM states: IDLE, EXEC, DONE.
- IDLE: on an edge with stb=1, latch command, snapshot reg[srcA] and reg[srcB] into operand buffers, and clear lane counter.
  - ALU opcode -> EXEC.
  - Any other opcode -> DONE.
- EXEC: compute one lane per cycle, lane 0 first, into the result buffer. After lane LANES-1 -> DONE.
- DONE: ack=1 for exactly this cycle; commit result; -> IDLE.
  - Master must change command or drop stb at the edge where it samples ack=1.
  - Back-to-back commands are accepted in the cycle after DONE.
- Opcodes:
  - 0 READ: data_out <= reg[srcA] at commit.
  - 1 LOAD: reg[dst] <= data_in (sampled at accept).
  - 2 ADD.
  - 3 SUB (A-B).
  - 4 MUL (low LANE_W bits of product).
  - 5 AND, 6 OR, 7 XOR.
  - 8-15 illegal: ack with err=1, no state change, data_out held.
- Arithmetic is per-lane unsigned; no carries cross lanes.
- sat=0: wrap modulo 2^LANE_W.
- sat=1:
  - ADD clamps to all-ones on carry-out.
  - SUB clamps to 0 on borrow.
  - MUL clamps to all-ones if any upper product bit is set.
  - Logic ops ignore sat.
- Latency (accept edge = N): READ/LOAD/illegal ack high in cycle N+1. ALU ops ack high in cycle N+LANES+1.
- data_out changes only on READ commit; it holds through all other ops.
- dst may equal srcA/srcB: operands are snapshotted, so the result uses pre-op values.
- The destination register is written only at DONE. Reset or abort mid-EXEC leaves reg[dst] unchanged (it is zeroed by reset anyway); no partial lane writes are ever visible.
- stb=0 in IDLE: no activity, ack=0.
- stb dropped during EXEC: ignored, the op completes and acks.
- Reserved command bits have no effect.

Test Plan:
All scenarios use default params and clk period 25 ns.
- Reset then idle: rst_n low 2 cycles, stb=0 for 10 cycles -> ack=0, err=0, data_out=0 throughout; READ r5 -> data_out=0.
- LOAD/READ latency: LOAD r0=0x3000_2000_1000_0000, then READ r0 -> each ack exactly 1 cycle, 1 cycle after accept; data_out=0x3000_2000_1000_0000.
- ADD/SUB wrap: LOAD r1=0x7000_6000_5000_4000, ADD r2=r0+r1 -> ack 5 cycles after accept, READ r2 = 0xA000_8000_6000_4000; SUB r3=r0-r1 (sat=0) -> 0xC000_C000_C000_C000; same with sat=1 -> 0.
- MUL and saturation:
  - r4=0x0070_0060_0050_0040, r5=0x0010_0020_0030_0040, MUL -> 0x0700_0C00_0F00_1000.
  - r6=0xFFFF_8000_0001_0000, ADD sat=1 r6+r6 -> 0xFFFF_FFFF_0002_0000.
  - Same with sat=0 -> 0xFFFE_0000_0002_0000.
- Aliasing/illegal: ADD r0=r0+r0 -> r0=0x6000_4000_2000_0000; opcode 9 -> ack with err=1, all registers and data_out unchanged; next command err=0.
- Reset mid-EXEC: assert rst_n=0 two cycles into an ADD -> ack never pulses for it, FSM IDLE, all regs 0; a following LOAD/READ works normally.
